acc_unit: RTL

//  Consumer end of the CiM ALU datapath: takes the per-beat results of an
//  ALU (XNOR or multiply) and reduces them into one dot-product value.

---
 rtl/acc_pkg.sv | 18 +
 rtl/acc_unit_popcount.sv | 20 ++
 rtl/acc_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared CiM datapath definitions: accumulator FSM states and ALU kind codes.
// Also imported by the ALU so both ends agree on the ALU_KIND encoding.
package acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int ALU_XNOR = 0;
   localparam int ALU_MUL  = 1;

   function automatic int pop_width(input int data_width);
      return $clog2(data_width + 1);
   endfunction

endpackage

// File: rtl/acc_unit_popcount.sv
// Combinational popcount of one ALU beat, zero latency, no flow control.
// Output width is just wide enough to hold DATA_WIDTH itself.
module popcount_unit
   import acc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = pop_width(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] data,
   output logic [CNT_WIDTH-1:0]  count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         count = count + CNT_WIDTH'(data[i]);
      end
   end

endmodule

// File: rtl/acc_unit.sv
// Reduces a job of len_i ALU beats into one dot-product result; result valid 1 cycle after the last beat.
// Beats stall on data_ready_o outside ACC; result is held in DONE until res_ready_i. Optional: ACC_SAT_EN.
module acc_unit
   import acc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ALU_KIND   = 0,
   parameter int ACC_WIDTH  = 48,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   input  logic                  data_valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  data_ready_o,
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [ACC_WIDTH-1:0]  res_o,
   output logic                  busy_o
);

   localparam int CNT_WIDTH = pop_width(DATA_WIDTH);

   state_t               state;
   logic [ACC_WIDTH-1:0] acc;
   logic [LEN_WIDTH-1:0] count;
   logic [ACC_WIDTH-1:0] term;
   logic [ACC_WIDTH-1:0] sum;
   logic [ACC_WIDTH-1:0] acc_next;

   generate
      if (ALU_KIND == ALU_XNOR) begin : g_xnor
         logic [CNT_WIDTH-1:0] pop;
         popcount_unit #(
            .DATA_WIDTH (DATA_WIDTH),
            .CNT_WIDTH  (CNT_WIDTH)
         ) u_popcount (
            .data  (data_i),
            .count (pop)
         );
         assign term = {{(ACC_WIDTH-CNT_WIDTH){1'b0}}, pop};
      end else if (ALU_KIND == ALU_MUL) begin : g_mul
         assign term = {{(ACC_WIDTH-DATA_WIDTH){data_i[DATA_WIDTH-1]}}, data_i};
      end else begin : g_none
         assign term = '0;
      end
   endgenerate

   assign sum = acc + term;

`ifdef ACC_SAT_EN
   logic                 sat;
   logic                 sat_hit;

   // Overflow is judged on the wrapped sum: unsigned carry for popcounts, sign flip for signed beats.
   always_comb begin
      sat_hit  = 1'b0;
      acc_next = sum;
      if (ALU_KIND == ALU_XNOR) begin
         if (sum < acc) begin
            sat_hit  = 1'b1;
            acc_next = '1;
         end
      end else if (ALU_KIND == ALU_MUL) begin
         if ((acc[ACC_WIDTH-1] == term[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1])) begin
            sat_hit  = 1'b1;
            acc_next = acc[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                        : {1'b0, {(ACC_WIDTH-1){1'b1}}};
         end
      end
   end
`else
   assign acc_next = sum;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state        <= IDLE;
         acc          <= '0;
         count        <= '0;
         data_ready_o <= 1'b0;
         res_valid_o  <= 1'b0;
         busy_o       <= 1'b0;
`ifdef ACC_SAT_EN
         sat          <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  acc    <= '0;
                  busy_o <= 1'b1;
`ifdef ACC_SAT_EN
                  sat    <= 1'b0;
`endif
                  if (len_i != '0) begin
                     count        <= len_i;
                     data_ready_o <= 1'b1;
                     state        <= ACC;
                  end else begin
                     res_valid_o  <= 1'b1;
                     state        <= DONE;
                  end
               end
            end
            ACC: begin
               if (data_valid_i) begin
`ifdef ACC_SAT_EN
                  // Once pinned at a rail the accumulator ignores the rest of the job.
                  if (!sat) begin
                     acc <= acc_next;
                     sat <= sat_hit;
                  end
`else
                  acc <= acc_next;
`endif
                  count <= count - LEN_WIDTH'(1);
                  if (count == LEN_WIDTH'(1)) begin
                     data_ready_o <= 1'b0;
                     res_valid_o  <= 1'b1;
                     state        <= DONE;
                  end
               end
            end
            DONE: begin
               if (res_ready_i) begin
                  res_valid_o <= 1'b0;
                  busy_o      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               data_ready_o <= 1'b0;
               res_valid_o  <= 1'b0;
               busy_o       <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

   assign res_o = acc;

endmodule
